// File: rtl/mul_div_unit.sv
// Multiply/divide unit for the EX stage: multi-cycle mult/multu/div/divu,
// single-cycle mthi/mtlo, HI/LO readback for mfhi/mflo, and a stall output
// for the hazard unit. The result is computed when the operation is
// accepted and held in pending registers. It is committed to HI/LO when the
// busy down-counter reaches its terminal count.
module mul_div_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        rd_sel,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_wr;

   logic        multi_op;
   logic [63:0] prod;
   logic        is_div_s;
   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic [31:0] dvs_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_wr;

   assign multi_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   assign md_stall = busy | (start & multi_op);
   assign rd_data  = rd_sel ? hi : lo;

   // Result of the operation presented this cycle, captured only on acceptance.
   // Signed division works on magnitudes so truncation toward zero and the
   // remainder-follows-dividend rule fall out directly; this also yields
   // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
   always_comb begin
      res_hi   = hi;
      res_lo   = lo;
      res_wr   = 1'b0;
      is_div_s = (op == OP_DIV);
      prod     = 64'd0;
      dvd_mag  = (is_div_s && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
      dvs_mag  = (is_div_s && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
      // A zero divisor never commits, so substitute 1 to keep the divider defined.
      dvs_safe = (rt_val == 32'd0) ? 32'd1 : dvs_mag;
      q_mag    = dvd_mag / dvs_safe;
      r_mag    = dvd_mag % dvs_safe;
      case (op)
         OP_MULT: begin
            prod   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
         end
         OP_MULTU: begin
            prod   = {32'd0, rs_val} * {32'd0, rt_val};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            res_lo = (is_div_s && (rs_val[31] ^ rt_val[31])) ? (32'd0 - q_mag) : q_mag;
            res_hi = (is_div_s && rs_val[31]) ? (32'd0 - r_mag) : r_mag;
            res_wr = (rt_val != 32'd0);
         end
         default: ;
      endcase
   end

   // Busy down-counter, pending result commit, and mthi/mtlo writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi      <= 32'd0;
         lo      <= 32'd0;
         busy    <= 1'b0;
         cnt     <= '0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            busy <= 1'b0;
            if (pend_wr) begin
               hi <= pend_hi;
               lo <= pend_lo;
            end
         end
      end else if (start) begin
         if (multi_op) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            busy    <= 1'b1;
            cnt     <= ((op == OP_MULT) || (op == OP_MULTU)) ? CNT_W'(MUL_CYCLES)
                                                              : CNT_W'(DIV_CYCLES);
         end else if (op == OP_MTHI) begin
            hi <= rs_val;
         end else if (op == OP_MTLO) begin
            lo <= rs_val;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit. Stimulus pushes expected HI/LO and busy length
// into a queue; a monitor pops and compares whenever busy drops.
module tb_mul_div_unit;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic        rd_sel;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd_data;

   mul_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .rd_sel(rd_sel),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .md_stall(md_stall),
      .hi(hi), .lo(lo), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   int          busy_len = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: count busy cycles, compare against the scoreboard when busy drops.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         busy_len = 0;
      end else if (busy) begin
         busy_len++;
      end else if (busy_len > 0) begin
         if (sb.size() == 0) begin
            check("unexpected_completion", 32'(busy_len), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("busy_len", 32'(busy_len), 32'(e.n));
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
         end
         busy_len = 0;
      end
   end

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sp;
      longint unsigned up;
      longint          sa, sbv, q, r;
      exp_t            e;
      case (o)
         3'd1: begin
            sp = longint'(int'(a)) * longint'(int'(b));
            m_hi = sp[63:32]; m_lo = sp[31:0];
            e.n = MUL_N;
         end
         3'd2: begin
            up = longint'({32'd0, a}) * longint'({32'd0, b});
            m_hi = up[63:32]; m_lo = up[31:0];
            e.n = MUL_N;
         end
         3'd3: begin
            if (b != 0) begin
               sa = longint'(int'(a)); sbv = longint'(int'(b));
               q = sa / sbv; r = sa % sbv;
               m_lo = q[31:0]; m_hi = r[31:0];
            end
            e.n = DIV_N;
         end
         3'd4: begin
            if (b != 0) begin
               m_lo = a / b; m_hi = a % b;
            end
            e.n = DIV_N;
         end
         3'd5: m_hi = a;
         3'd6: m_lo = a;
         default: ;
      endcase
      if (o >= 3'd1 && o <= 3'd4) begin
         e.hi = m_hi; e.lo = m_lo;
         sb.push_back(e);
      end
   endtask

   // Issue one instruction from an idle state; called just after a negedge.
   task automatic issue(input logic st, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      start = st; op = o; rs_val = a; rt_val = b;
      #1;
      check("md_stall_issue", {31'd0, md_stall}, {31'd0, st && (o >= 3'd1) && (o <= 3'd4)});
      if (st) model_op(o, a, b);
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         @(negedge clk);
         #1;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'd0; rd_sel = 1'b0;
      rs_val = 32'd0; rt_val = 32'd0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_stall", {31'd0, md_stall}, 32'd0);

      // mult -2*3; md_stall held for the busy window
      issue(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
      for (int i = 0; i < MUL_N; i++) begin
         check("md_stall_busy", {31'd0, md_stall}, 32'd1);
         @(negedge clk);
         #1;
      end
      wait_idle();
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);

      issue(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle();
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      // div -7/2 with an mthi attempted while busy
      issue(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
      start = 1'b1; op = 3'd5; rs_val = 32'hDEAD_BEEF;
      #1 check("md_stall_busy_mthi", {31'd0, md_stall}, 32'd1);
      @(posedge clk);
      #1 start = 1'b0; op = 3'd0;
      @(negedge clk);
      #1 wait_idle();
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);

      issue(1'b1, 3'd4, 32'd7, 32'd0);
      wait_idle();
      check("divu0_hi", hi, 32'hFFFF_FFFF);
      check("divu0_lo", lo, 32'hFFFF_FFFD);

      issue(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      check("divovf_lo", lo, 32'h8000_0000);
      check("divovf_hi", hi, 32'd0);

      issue(1'b1, 3'd6, 32'h1234_5678, 32'd0);
      rd_sel = 1'b0;
      #1;
      check("mtlo_busy", {31'd0, busy}, 32'd0);
      check("mtlo_lo", lo, 32'h1234_5678);
      check("mtlo_rd", rd_data, 32'h1234_5678);

      // reset during a div 100/7 discards the pending result
      issue(1'b1, 3'd3, 32'd100, 32'd7);
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      repeat (15) @(negedge clk);
      #1;
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      check("rst_mid_busy_late", {31'd0, busy}, 32'd0);

      // randomized run, including back-to-back issues
      for (int it = 0; it < 120; it++) begin
         logic [2:0]  o;
         logic [31:0] a, b;
         logic        st;
         wait_idle();
         rd_sel = 1'($urandom_range(0, 1));
         #1 check("rd_data", rd_data, rd_sel ? m_hi : m_lo);
         o  = 3'($urandom_range(0, 7));
         st = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 3))
            0: a = 32'h8000_0000;
            1: a = 32'($urandom_range(0, 20)) - 32'd10;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 9));
            default: b = $urandom;
         endcase
         issue(st, o, a, b);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            #1;
         end
      end
      wait_idle();
      @(negedge clk);
      #1;
      check("final_hi", hi, m_hi);
      check("final_lo", lo, m_lo);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multiply/divide unit with HI/LO registers. Lives in the EX stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu as multi-cycle operations and handles mthi/mtlo writes.
- Exposes HI/LO for mfhi/mflo. The selected value travels down the pipeline registers as the mlu result and is written back in WB.
- Drives a stall indication consumed by the hazard unit.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage instruction is valid and of MDU class this cycle.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfsel (read-only).
- rd_sel  input  1  read select: 0 = LO, 1 = HI.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- busy  output  1  registered; operation in progress.
- md_stall  output  1  combinational: busy | (start & op in 1..4). The hazard unit stalls any MDU-class instruction in D when this is high.
- hi  output  32  registered HI.
- lo  output  32  registered LO.
- rd_data  output  32  combinational: rd_sel ? hi : lo.

Behaviour:
- Reset: clk and reset are as declared above (synchronous, active-high).
  - On a reset edge: hi = 0, lo = 0, busy = 0, internal counter = 0, latched operands and pending result cleared.
  - Reset has priority over every other input.
  - Reset mid-operation discards the pending result. HI/LO read 0 afterwards, never the partial result.
- Idle (busy = 0), start = 1, op in 1..4, sampled at edge T:
  - Operands latched and result computed into internal pending registers.
  - Counter loaded with MUL_CYCLES or DIV_CYCLES; busy = 1 from T.
  - Counter decrements each edge. On the edge where the counter goes 1 -> 0, pending result is written to hi/lo and busy falls in the same edge.
  - hi/lo therefore hold the new value exactly N edges after T (N = MUL_CYCLES or DIV_CYCLES), with busy high for N cycles.
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit rs*rt.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divisor 0: busy runs the full DIV_CYCLES, hi/lo unchanged.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mthi/mtlo with busy = 0:
  - hi (or lo) = rs_val at that edge; single cycle, busy stays 0.
- While busy = 1:
  - start with any op is ignored; no state change.
  - The hazard unit guarantees this does not happen. The RTL must still be safe if it does.
- op 0 or 7, or start = 0: no state change.
- rd_data:
  - Reflects current registered hi/lo only; no bypass of an in-flight result.
  - An mfhi/mflo in EX is stalled by md_stall until busy = 0.
- Counter width: wide enough for max(MUL_CYCLES, DIV_CYCLES). No wrap; counter holds at 0 when idle.
- Back-to-back:
  - A new start is accepted on the first edge where busy = 0, i.e. the edge after the final write.
  - That edge sees busy = 0, the new op is accepted, and its result overwrites hi/lo later.

Test Plan:
- Reset, then mult rs = 0xFFFFFFFE (-2), rt = 3 at edge T -> busy = 1 for cycles T..T+4; at T+5 hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, busy = 0.
- multu rs = 0xFFFFFFFF, rt = 0xFFFFFFFF -> after 5 cycles hi = 0xFFFFFFFE, lo = 0x00000001.
- div rs = -7 (0xFFFFFFF9), rt = 2 -> after 10 cycles lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); divu 7/0 -> hi/lo unchanged after 10 busy cycles.
- mtlo rs = 0x12345678 then rd_sel = 0 -> lo and rd_data = 0x12345678 the next cycle, busy never asserts. A start mthi issued while busy during a div -> hi unaffected.
- md_stall: start with op = mult while idle -> md_stall = 1 combinationally that cycle and stays 1 for the following 5 cycles; op = mthi while idle -> md_stall = 0.
- Reset asserted at cycle 3 of a div 100/7 -> busy = 0, hi = lo = 0 after reset, no later write of 14/2.
